// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path (port 0)
// and the UART debug/loader (port 1); one access in flight at a time.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbg_prio,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [2:0]    size0,
  input  logic [2:0]    size1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [2:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_owner;
  logic       r_last;
  logic       r_wr;
  logic       w_any;
  logic       w_pick;

  // Returns the winning port; a tie under round-robin goes to the port not granted last.
  function automatic logic pick_port(input logic q0, input logic q1,
                                     input logic prio, input logic last);
    if (prio && q1) return 1'b1;
    if (q0 && q1)   return ~last;
    return q1;
  endfunction

  assign w_any  = req0 | req1;
  assign w_pick = pick_port(req0, req1, dbg_prio, r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_wr      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (r_state)
        // IDLE and ACK both accept a new request; gnt/mem_en are launched here
        // so they appear in the ISSUE cycle.
        S_IDLE, S_ACK: begin
          if (w_any) begin
            r_owner   <= w_pick;
            r_last    <= w_pick;
            r_wr      <= w_pick ? wr1 : wr0;
            mem_we    <= w_pick ? wr1 : wr0;
            mem_size  <= w_pick ? size1 : size0;
            mem_addr  <= w_pick ? addr1 : addr0;
            mem_wdata <= w_pick ? wdata1 : wdata0;
            gnt0      <= ~w_pick;
            gnt1      <= w_pick;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            if (!r_wr && !r_owner) rdata0 <= mem_rdata;
            if (!r_wr &&  r_owner) rdata1 <= mem_rdata;
            ack0    <= ~r_owner;
            ack1    <= r_owner;
            r_cnt   <= '0;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a MEM_LAT=1 instance for most scenarios and a
// MEM_LAT=4 instance for the latency sweep.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dbg_prio = 1'b0;
  logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [2:0]  size0 = 0, size1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  logic        b_req0 = 0;
  logic [31:0] b_addr0 = 0, b_mem_rdata = 0;
  logic        b_gnt0, b_gnt1, b_ack0, b_ack1, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata;
  logic [2:0]  b_mem_size;

  int checks = 0;
  int errors = 0;

  wire [6:0] st = {gnt0, gnt1, ack0, ack1, mem_en, mem_we, busy};

  // Memory model: one known word, otherwise a pattern derived from the address.
  assign mem_rdata = (mem_addr == 32'h10) ? 32'hDEADBEEF : {16'h5A5A, mem_addr[15:0]};

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .dbg_prio(dbg_prio),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .dbg_prio(1'b0),
    .req0(b_req0), .req1(1'b0), .wr0(1'b0), .wr1(1'b0),
    .size0(3'd2), .size1(3'd0), .addr0(b_addr0), .addr1(32'h0),
    .wdata0(32'h0), .wdata1(32'h0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .ack0(b_ack0), .ack1(b_ack1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_size(b_mem_size),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (st !== 7'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_size !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs st=%b rdata0=%h rdata1=%h addr=%h wdata=%h size=%0d want all 0",
               st, rdata0, rdata1, mem_addr, mem_wdata, mem_size);
    end
    step;
    reset = 1'b1;
    step;
    checks++;
    if (st !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle st=%b want 0000000", st);
    end
  endtask

  task automatic test_single_read;
    addr0 = 32'h10; wr0 = 1'b0; size0 = 3'd2; req0 = 1'b1;
    step;
    checks++;
    if (st !== 7'b1000101 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL rd_issue st=%b addr=%h want 1000101 addr 10", st, mem_addr);
    end
    req0 = 1'b0;
    step;
    checks++;
    if (st !== 7'b0000001) begin
      errors++;
      $display("FAIL rd_wait st=%b want 0000001", st);
    end
    step;
    checks++;
    if (st !== 7'b0010001 || rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_ack st=%b rdata0=%h want 0010001 deadbeef", st, rdata0);
    end
    step;
    checks++;
    if (st !== 7'b0 || rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_idle st=%b rdata0=%h want 0000000 deadbeef", st, rdata0);
    end
  endtask

  task automatic test_single_write;
    addr1 = 32'h8; wr1 = 1'b1; wdata1 = 32'hA5; size1 = 3'd2; req1 = 1'b1;
    step;
    checks++;
    if (st !== 7'b0100111 || mem_wdata !== 32'hA5 || mem_size !== 3'd2 || mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL wr_issue st=%b wdata=%h size=%0d addr=%h want 0100111 a5 2 8",
               st, mem_wdata, mem_size, mem_addr);
    end
    req1 = 1'b0;
    step;
    checks++;
    if (st !== 7'b0000001 || mem_addr !== 32'h8 || mem_wdata !== 32'hA5) begin
      errors++;
      $display("FAIL wr_wait st=%b addr=%h wdata=%h want 0000001 8 a5", st, mem_addr, mem_wdata);
    end
    step;
    checks++;
    if (st !== 7'b0001001 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL wr_ack st=%b rdata1=%h want 0001001 0", st, rdata1);
    end
    step;
    checks++;
    if (st !== 7'b0 || rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_idle st=%b rdata0=%h want 0000000 deadbeef", st, rdata0);
    end
  endtask

  task automatic test_round_robin;
    logic g0, g1, a0, a1;
    logic [6:0] exp;
    reset = 1'b0;
    step;
    reset = 1'b1;
    wr0 = 1'b0; wr1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step;
      g0 = (c % 6 == 1); g1 = (c % 6 == 4); a0 = (c % 6 == 3); a1 = (c % 6 == 0);
      exp = {g0, g1, a0, a1, g0 | g1, 1'b0, 1'b1};
      checks++;
      if (st !== exp) begin
        errors++;
        $display("FAIL rr_cycle%0d st=%b want %b", c, st, exp);
      end
      if (c == 3) begin
        checks++;
        if (rdata0 !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rr_rdata0 got %h want deadbeef", rdata0);
        end
      end
      if (c == 6) begin
        checks++;
        if (rdata1 !== 32'h5A5A0020) begin
          errors++;
          $display("FAIL rr_rdata1 got %h want 5a5a0020", rdata1);
        end
      end
      if (c == 12) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    step;
    checks++;
    if (st !== 7'b0) begin
      errors++;
      $display("FAIL rr_idle st=%b want 0000000", st);
    end
  endtask

  task automatic test_dbg_prio;
    logic g1, a1;
    logic [6:0] exp;
    req0 = 1'b1;
    step;
    checks++;
    if (st !== 7'b1000101) begin
      errors++;
      $display("FAIL dp_lone0 st=%b want 1000101", st);
    end
    req0 = 1'b0;
    step; step; step;
    dbg_prio = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step;
      g1 = (c % 3 == 1); a1 = (c % 3 == 0);
      exp = {1'b0, g1, 1'b0, a1, g1, 1'b0, 1'b1};
      checks++;
      if (st !== exp) begin
        errors++;
        $display("FAIL dp_cycle%0d st=%b want %b", c, st, exp);
      end
      if (c == 9) dbg_prio = 1'b0;
    end
    step;
    checks++;
    if (st !== 7'b1000101) begin
      errors++;
      $display("FAIL dp_release st=%b want 1000101", st);
    end
    req0 = 1'b0; req1 = 1'b0;
    step; step;
    checks++;
    if (st !== 7'b0010001) begin
      errors++;
      $display("FAIL dp_ack0 st=%b want 0010001", st);
    end
    step;
  endtask

  task automatic test_latency;
    b_addr0 = 32'h40; b_req0 = 1'b1; b_mem_rdata = 32'hC0DE0000;
    step;
    b_mem_rdata = 32'hC0DE0001;
    checks++;
    if (b_gnt0 !== 1'b1 || b_mem_en !== 1'b1 || b_ack0 !== 1'b0) begin
      errors++;
      $display("FAIL lat_issue gnt0=%b mem_en=%b ack0=%b want 1 1 0", b_gnt0, b_mem_en, b_ack0);
    end
    b_req0 = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      step;
      b_mem_rdata = 32'hC0DE0000 + 32'(c);
      checks++;
      if (b_ack0 !== (c == 6)) begin
        errors++;
        $display("FAIL lat_ack_cycle%0d ack0=%b want %b", c, b_ack0, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (b_rdata0 !== 32'hC0DE0005) begin
          errors++;
          $display("FAIL lat_rdata got %h want c0de0005", b_rdata0);
        end
      end
    end
    step;
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_idle busy=%b want 0", b_busy);
    end
  endtask

  task automatic test_reset_wait;
    addr0 = 32'h10; req0 = 1'b1;
    step;
    req0 = 1'b0;
    step;
    checks++;
    if (st !== 7'b0000001) begin
      errors++;
      $display("FAIL rw_wait st=%b want 0000001", st);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (st !== 7'b0 || rdata0 !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        mem_size !== 3'd0) begin
      errors++;
      $display("FAIL rw_async st=%b rdata0=%h addr=%h wdata=%h size=%0d want all 0",
               st, rdata0, mem_addr, mem_wdata, mem_size);
    end
    for (int k = 0; k < 2; k++) begin
      step;
      checks++;
      if (st !== 7'b0) begin
        errors++;
        $display("FAIL rw_held%0d st=%b want 0000000", k, st);
      end
    end
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step;
    checks++;
    if (st !== 7'b1000101) begin
      errors++;
      $display("FAIL rw_first_gnt st=%b want 1000101", st);
    end
    req0 = 1'b0; req1 = 1'b0;
    step; step; step;
    checks++;
    if (st !== 7'b0) begin
      errors++;
      $display("FAIL rw_idle st=%b want 0000000", st);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_round_robin;
    test_dbg_prio;
    test_latency;
    test_reset_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
